// File: rtl/axi_lite_user_master.sv
// Command-driven AXI4-Lite master: one single-word read or write per accepted command, one outstanding.
// Defining AXIL_MST_ERRCNT_EN adds a saturating counter of non-OKAY responses on err_cnt.
module axi_lite_user_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   // user command port
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   // user response port
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_we,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic [15:0]           err_cnt,
   // AXI4-Lite write address
   output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]            M_AXI_AWPROT,
   output logic                  M_AXI_AWVALID,
   input  logic                  M_AXI_AWREADY,
   // AXI4-Lite write data
   output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic [3:0]            M_AXI_WSTRB,
   output logic                  M_AXI_WVALID,
   input  logic                  M_AXI_WREADY,
   // AXI4-Lite write response
   input  logic [1:0]            M_AXI_BRESP,
   input  logic                  M_AXI_BVALID,
   output logic                  M_AXI_BREADY,
   // AXI4-Lite read address
   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]            M_AXI_ARPROT,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   // AXI4-Lite read data
   input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY
);

   if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("axi_lite_user_master: DATA_WIDTH must be 32");
   end

   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_B,
      ST_RD_A,
      ST_RD_D,
      ST_RSP
   } state_e;

   state_e                state_q, state_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  arvalid_q, arvalid_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  rsp_we_q, rsp_we_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]            rsp_resp_q, rsp_resp_d;

   logic cmd_hs, aw_hs, w_hs, ar_hs, b_hs, r_hs;

   // Held low while ARESET is asserted so no command can slip in during reset.
   assign cmd_ready = (state_q == ST_IDLE) && !ARESET;

   assign cmd_hs = cmd_valid && cmd_ready;
   assign aw_hs  = awvalid_q && M_AXI_AWREADY;
   assign w_hs   = wvalid_q && M_AXI_WREADY;
   assign ar_hs  = arvalid_q && M_AXI_ARREADY;
   assign b_hs   = (state_q == ST_WR_B) && M_AXI_BVALID;
   assign r_hs   = (state_q == ST_RD_D) && M_AXI_RVALID;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      rsp_we_d    = rsp_we_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_hs) begin
               addr_d    = cmd_addr & ADDR_MASK;
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               rsp_we_d  = cmd_we;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (cmd_we) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_WR;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = ST_RD_A;
               end
            end
         end

         // AW and W complete independently; leave once both have, even in the same cycle.
         ST_WR: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d = ST_WR_B;
            end
         end

         ST_WR_B: begin
            if (b_hs) begin
               rsp_rdata_d = '0;
               rsp_resp_d  = M_AXI_BRESP;
               state_d     = ST_RSP;
            end
         end

         ST_RD_A: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               state_d   = ST_RD_D;
            end
         end

         ST_RD_D: begin
            if (r_hs) begin
               rsp_rdata_d = M_AXI_RDATA;
               rsp_resp_d  = M_AXI_RRESP;
               state_d     = ST_RSP;
            end
         end

         ST_RSP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      // NOTE: sequential state uses non-blocking assignments; the synchronous reset clears every flop.
      if (ARESET) begin
         state_q     <= ST_IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         rsp_we_q    <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         rsp_we_q    <= rsp_we_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
      end
   end

`ifdef AXIL_MST_ERRCNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   // Saturating count of SLVERR/DECERR (or any non-OKAY) responses on B and R.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (((b_hs && (M_AXI_BRESP != 2'b00)) || (r_hs && (M_AXI_RRESP != 2'b00)))
          && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         err_cnt_q <= 16'h0000;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   assign err_cnt = 16'h0000;
`endif

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = (state_q == ST_WR_B);
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = (state_q == ST_RD_D);

   assign rsp_valid = (state_q == ST_RSP);
   assign rsp_we    = rsp_we_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;

endmodule
